// File: rtl/tcb_lib_pkg.sv
// Shared types and helpers for the TCB library arbiter: manager index type and the
// rotate-and-priority-encode search used by the grant logic.
package tcb_lib_pkg;

    localparam int unsigned TCB_ARB_MPN_MAX = 16;
    localparam int unsigned TCB_ARB_IDX_MAX_W = 4;

    // Wide enough for the largest supported manager count; instances narrow it.
    typedef logic [TCB_ARB_IDX_MAX_W-1:0] tcb_arb_idx_t;

    typedef struct packed {
        logic         vld;
        tcb_arb_idx_t idx;
    } tcb_arb_sel_t;

    // Index width for a given manager count; a single manager still needs one bit.
    function automatic int unsigned tcb_arb_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First asserted vld bit at or after ptr, searching upward and wrapping at n-1.
    function automatic tcb_arb_sel_t tcb_arb_rr_pick(
        input logic [TCB_ARB_MPN_MAX-1:0] vld,
        input int unsigned                n,
        input tcb_arb_idx_t               ptr
    );
        tcb_arb_sel_t sel;
        int unsigned  pos;
        sel = '{vld: 1'b0, idx: '0};
        for (int unsigned k = 0; k < TCB_ARB_MPN_MAX; k++) begin
            pos = int'(ptr) + k;
            if (pos >= n) pos = pos - n;
            if (!sel.vld && (k < n) && vld[pos[TCB_ARB_IDX_MAX_W-1:0]]) begin
                sel.vld = 1'b1;
                sel.idx = pos[TCB_ARB_IDX_MAX_W-1:0];
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/tcb_lib_arbiter_grant.sv
// Combinational grant selection: lock owner when locked, otherwise the first requester
// at or after the round-robin pointer.
module tcb_lib_arbiter_grant
    import tcb_lib_pkg::*;
#(
    parameter int unsigned MPN = 2,
    parameter int unsigned IW  = 1
) (
    input  logic [MPN-1:0] vld,
    input  logic [IW-1:0]  ptr,
    input  logic           lck,
    input  logic [IW-1:0]  own,
    output logic [IW-1:0]  g,
    output logic           gnt_vld
);

    logic [TCB_ARB_MPN_MAX-1:0] vld_ext;
    tcb_arb_idx_t               ptr_ext;
    tcb_arb_sel_t               sel;

    always_comb begin
        vld_ext = TCB_ARB_MPN_MAX'(vld);
        ptr_ext = tcb_arb_idx_t'(ptr);
        sel     = tcb_arb_rr_pick(vld_ext, MPN, ptr_ext);
        if (lck) begin
            // The owner keeps the subordinate even while idle.
            g       = own;
            gnt_vld = vld_ext[own];
        end else begin
            g       = IW'(sel.idx);
            gnt_vld = sel.vld;
        end
    end

endmodule

// File: rtl/tcb_lib_arbiter.sv
// Shares one TCB subordinate between MPN managers with lock-aware round-robin grant and
// DLY-deep response routing. Define TCB_LIB_ARBITER_FIXED_PRIORITY_EN for fixed priority.
module tcb_lib_arbiter
    import tcb_lib_pkg::*;
#(
    parameter int unsigned MPN = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned SW  = 8,
    parameter int unsigned BW  = DW / SW,
    parameter int unsigned DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MPN-1:0]    man_vld,
    input  logic [MPN-1:0]    man_wen,
    input  logic [MPN*AW-1:0] man_adr,
    input  logic [MPN*BW-1:0] man_ben,
    input  logic [MPN*DW-1:0] man_wdt,
    input  logic [MPN-1:0]    man_lck,
    input  logic [MPN-1:0]    man_rpt,
    output logic [MPN-1:0]    man_rdy,
    output logic [MPN*DW-1:0] man_rdt,
    output logic [MPN-1:0]    man_err,
    output logic             sub_vld,
    output logic             sub_wen,
    output logic [AW-1:0]     sub_adr,
    output logic [BW-1:0]     sub_ben,
    output logic [DW-1:0]     sub_wdt,
    output logic             sub_lck,
    output logic             sub_rpt,
    input  logic             sub_rdy,
    input  logic [DW-1:0]     sub_rdt,
    input  logic             sub_err
);

    localparam int unsigned IW = tcb_arb_idx_w(MPN);

    logic [IW-1:0] g;
    logic [IW-1:0] ptr;
    logic [IW-1:0] own_q;
    logic          lck_q;
    logic          gnt_vld;
    logic          trn;
    logic          rte_vld;
    logic [IW-1:0] rte_idx;

    tcb_lib_arbiter_grant #(
        .MPN (MPN),
        .IW  (IW)
    ) u_grant (
        .vld     (man_vld),
        .ptr     (ptr),
        .lck     (lck_q),
        .own     (own_q),
        .g       (g),
        .gnt_vld (gnt_vld)
    );

    assign sub_vld = gnt_vld & ~rst;
    assign trn     = sub_vld & sub_rdy;

    always_comb begin
        sub_wen = 1'b0;
        sub_adr = '0;
        sub_ben = '0;
        sub_wdt = '0;
        sub_lck = 1'b0;
        sub_rpt = 1'b0;
        man_rdy = '0;
        if (sub_vld) begin
            sub_wen    = man_wen[g];
            sub_adr    = man_adr[int'(g)*AW +: AW];
            sub_ben    = man_ben[int'(g)*BW +: BW];
            sub_wdt    = man_wdt[int'(g)*DW +: DW];
            sub_lck    = man_lck[g];
            sub_rpt    = man_rpt[g];
            man_rdy[g] = sub_rdy;
        end
    end

`ifdef TCB_LIB_ARBITER_FIXED_PRIORITY_EN
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (trn) begin
            ptr_q <= (g == IW'(MPN - 1)) ? '0 : g + 1'b1;
        end
    end

    assign ptr = ptr_q;
`endif

    // While locked only the owner can transfer, so any unlocked transfer releases it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lck_q <= 1'b0;
            own_q <= '0;
        end else if (trn) begin
            if (sub_lck) begin
                lck_q <= 1'b1;
                own_q <= g;
            end else if (lck_q) begin
                lck_q <= 1'b0;
            end
        end
    end

    if (DLY == 0) begin : g_rsp_comb
        assign rte_vld = trn;
        assign rte_idx = g;
    end else begin : g_rsp_pipe
        logic [DLY-1:0] pv_q;
        logic [IW-1:0]  pi_q [DLY];

        always_ff @(posedge clk) begin
            if (rst) begin
                pv_q <= '0;
                for (int s = 0; s < DLY; s++) pi_q[s] <= '0;
            end else begin
                for (int s = DLY - 1; s > 0; s--) begin
                    pv_q[s] <= pv_q[s-1];
                    pi_q[s] <= pi_q[s-1];
                end
                pv_q[0] <= trn;
                pi_q[0] <= g;
            end
        end

        assign rte_vld = pv_q[DLY-1];
        assign rte_idx = pi_q[DLY-1];
    end

    always_comb begin
        man_rdt = '0;
        man_err = '0;
        if (rte_vld && !rst) begin
            man_rdt[int'(rte_idx)*DW +: DW] = sub_rdt;
            man_err[rte_idx]                = sub_err;
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// Randomized self-checking bench for tcb_lib_arbiter against a queue-based reference model.
module tb_tcb_lib_arbiter;

    localparam int unsigned MPN = 3;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 8;
    localparam int unsigned BW  = DW / SW;
    localparam int unsigned DLY = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [MPN-1:0]    man_vld, man_wen, man_lck, man_rpt, man_rdy, man_err;
    logic [MPN*AW-1:0] man_adr;
    logic [MPN*BW-1:0] man_ben;
    logic [MPN*DW-1:0] man_wdt, man_rdt;
    logic             sub_vld, sub_wen, sub_lck, sub_rpt, sub_rdy, sub_err;
    logic [AW-1:0]     sub_adr;
    logic [BW-1:0]     sub_ben;
    logic [DW-1:0]     sub_wdt, sub_rdt;

    always #5 clk = ~clk;

    tcb_lib_arbiter #(
        .MPN (MPN), .AW (AW), .DW (DW), .SW (SW), .BW (BW), .DLY (DLY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .man_vld (man_vld),
        .man_wen (man_wen),
        .man_adr (man_adr),
        .man_ben (man_ben),
        .man_wdt (man_wdt),
        .man_lck (man_lck),
        .man_rpt (man_rpt),
        .man_rdy (man_rdy),
        .man_rdt (man_rdt),
        .man_err (man_err),
        .sub_vld (sub_vld),
        .sub_wen (sub_wen),
        .sub_adr (sub_adr),
        .sub_ben (sub_ben),
        .sub_wdt (sub_wdt),
        .sub_lck (sub_lck),
        .sub_rpt (sub_rpt),
        .sub_rdy (sub_rdy),
        .sub_rdt (sub_rdt),
        .sub_err (sub_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: abstract pointer/lock state and a queue of pending response routes.
    int m_ptr = 0;
    int m_own = 0;
    bit m_lck = 1'b0;
    int rq[$];

    function automatic int pick();
        int idx;
        if (m_lck) return man_vld[m_own] ? m_own : -1;
        for (int k = 0; k < MPN; k++) begin
`ifdef TCB_LIB_ARBITER_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (m_ptr + k) % MPN;
`endif
            if (man_vld[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_lck = 1'b0;
        m_own = 0;
        rq.delete();
        for (int s = 0; s < DLY; s++) rq.push_back(-1);
    endtask

    // mode 0: all request, ready; 1: stalled; 2: random with locks; 3: sparse random
    task automatic drive(input int mode);
        for (int i = 0; i < MPN; i++) begin
            man_adr[i*AW +: AW] = AW'($urandom);
            man_ben[i*BW +: BW] = BW'($urandom);
            man_wdt[i*DW +: DW] = DW'($urandom);
            man_wen[i] = 1'($urandom);
            man_rpt[i] = 1'($urandom);
            case (mode)
                0, 1: begin
                    man_vld[i] = 1'b1;
                    man_lck[i] = 1'b0;
                end
                2: begin
                    man_vld[i] = ($urandom_range(0, 3) != 0);
                    man_lck[i] = ($urandom_range(0, 3) == 0);
                end
                default: begin
                    man_vld[i] = ($urandom_range(0, 2) == 0);
                    man_lck[i] = ($urandom_range(0, 7) == 0);
                end
            endcase
        end
        sub_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        sub_rdt = DW'($urandom);
        sub_err = 1'($urandom);
    endtask

    // Checks one cycle mid-period, then advances the model across the rising edge.
    task automatic step();
        int               g;
        int               route;
        bit               trn;
        logic [MPN*DW-1:0] e_rdt;
        logic [MPN-1:0]    e_err, e_rdy;
        #4;
        g     = rst ? -1 : pick();
        trn   = (g >= 0) && sub_rdy;
        route = rst ? -1 : ((DLY == 0) ? (trn ? g : -1) : rq[0]);
        e_rdt = '0;
        e_err = '0;
        e_rdy = '0;
        if (route >= 0) begin
            e_rdt[route*DW +: DW] = sub_rdt;
            e_err[route] = sub_err;
        end
        if (g >= 0) e_rdy[g] = sub_rdy;
        check("sub_vld", 128'(sub_vld), 128'(g >= 0));
        check("man_rdy", 128'(man_rdy), 128'(e_rdy));
        check("sub_adr", 128'(sub_adr), (g >= 0) ? 128'(man_adr[g*AW +: AW]) : 128'(0));
        check("sub_ben", 128'(sub_ben), (g >= 0) ? 128'(man_ben[g*BW +: BW]) : 128'(0));
        check("sub_wdt", 128'(sub_wdt), (g >= 0) ? 128'(man_wdt[g*DW +: DW]) : 128'(0));
        check("sub_ctl", 128'({sub_wen, sub_lck, sub_rpt}),
              (g >= 0) ? 128'({man_wen[g], man_lck[g], man_rpt[g]}) : 128'(0));
        check("man_rdt", 128'(man_rdt), 128'(e_rdt));
        check("man_err", 128'(man_err), 128'(e_err));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (trn) begin
                m_ptr = (g + 1) % MPN;
                if (man_lck[g]) begin
                    m_lck = 1'b1;
                    m_own = g;
                end else begin
                    m_lck = 1'b0;
                end
            end
            if (DLY > 0) begin
                void'(rq.pop_front());
                rq.push_back(trn ? g : -1);
            end
        end
        #1;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        drive(0);
        repeat (3) step();
        rst = 1'b0;
        for (int blk = 0; blk < 40; blk++) begin
            int mode;
            mode = (blk < 2) ? 0 : int'($urandom_range(0, 4));
            for (int c = 0; c < 20; c++) begin
                if (mode == 4) begin
                    // Reset right after a burst of transfers drops every pending response.
                    drive(0);
                    rst = (c == 3);
                end else begin
                    drive(mode);
                    rst = (mode >= 2) && ($urandom_range(0, 49) == 0);
                end
                step();
            end
            rst = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
